ip_activate_ctrl: RTL and testbench
===================================

# ip_activate_ctrl

Sequencer for the DRM activation comparator. It collects a 128-bit activation code from the host as four 32-bit words and drives the code onto the combinational comparator. After the comparator settles, it samples the result and holds a registered enable for the protected IP. It also counts failed attempts and, when configured, enforces a lockout window after repeated failures.

## Interface
Parameters:
- SETTLE_CYCLES, 2, cycles the code is held stable before the comparator result is sampled (range 1–15).
- MAX_FAILS, 3, consecutive failures that trigger lockout (range 1–15).
- LOCKOUT_CYCLES, 1024, lockout duration in cycles (range 1 to 2^20-1).

Ports (one clock; reset is asynchronous and active-low):
- clk_in  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  host presents a code word.
- wr_ready  out  1  block accepts a code word.
- wr_data  in  32  code word; the first word accepted is bits [127:96].
- check_req  in  1  single-cycle request to evaluate the loaded code.
- deactivate  in  1  single-cycle request to drop the enable.
- activation_code  out  128  code driven to the comparator.
- cmp_enable  in  1  comparator match result.
- cmp_rdy  in  1  comparator result valid.
- ip_enabled  out  1  registered enable for the protected IP.
- done  out  1  one-cycle pulse when a check completes.
- pass  out  1  valid with done: 1 means match.
- check_err  out  1  one-cycle pulse when check_req arrives outside the LOADED state.
- locked  out  1  lockout window active.
- fail_cnt  out  4  consecutive failure count.

## Operation
States: IDLE, LOADED, CHECK, ACTIVE, LOCKED.

- **IDLE**
  - wr_ready = 1 while word_cnt < 4.
  - Each accepted word (wr_valid && wr_ready) goes into the code register slot selected by word_cnt; word_cnt then increments.
  - After the 4th word, go to LOADED.
- **LOADED**
  - wr_ready = 0.
  - check_req → CHECK, with the settle counter loaded to SETTLE_CYCLES.
- **CHECK**
  - activation_code = code register; it is 0 in every other state.
  - The settle counter decrements each cycle.
  - At zero, with cmp_rdy = 1, sample cmp_enable. If cmp_rdy = 0, stay in CHECK until it asserts.
  - Match: ip_enabled ← 1, fail_cnt ← 0, go to ACTIVE.
  - Mismatch: fail_cnt ← fail_cnt + 1, saturating at 15.
    - If the new count ≥ MAX_FAILS: go to LOCKED and load the lockout timer.
    - Otherwise: go to IDLE.
  - In every case the code register and word_cnt are cleared and done pulses.
- **ACTIVE**
  - ip_enabled held at 1; wr_ready = 0.
  - deactivate → ip_enabled ← 0, go to IDLE.
- **LOCKED**
  - locked = 1; wr_ready = 0.
  - check_req produces check_err.
  - When the timer expires: fail_cnt ← 0, go to IDLE.

Boundary rules:
- check_req in IDLE (fewer than 4 words), CHECK, ACTIVE or LOCKED: ignored, and check_err pulses.
- check_req and deactivate in the same cycle: each is handled only if legal in the current state. They cannot both be legal at once.
- deactivate outside ACTIVE: ignored silently.
- wr_valid while wr_ready = 0: the word is dropped. The host must hold the word until wr_ready.

Reset (asynchronous, any state, including mid-load or mid-check):
- State goes to IDLE; word_cnt and the code register are zeroed.
- Outputs: wr_ready = 1; ip_enabled, done, pass, check_err, locked = 0; fail_cnt = 0; activation_code = 0.

## Timing
- A word is accepted on the clock edge where wr_valid && wr_ready. A 4-word load takes 4 cycles minimum.
- check_req sampled at edge N → CHECK from N+1.
- With cmp_rdy = 1, the result is sampled at edge N+SETTLE_CYCLES+1.
- done, pass and ip_enabled update together, visible after that edge.
- activation_code returns to 0 in the same cycle done is high.
- deactivate at edge M → ip_enabled = 0 after edge M.
- LOCKED lasts exactly LOCKOUT_CYCLES cycles, after which IDLE is entered and wr_ready = 1.
- All outputs are registered except wr_ready and activation_code, which decode the state register directly.

## Configuration
- ACT_CTRL_LOCKOUT_EN defined: lockout is enforced as described.
- Undefined:
  - The LOCKED state and lockout timer are removed and locked is tied to 0.
  - Every mismatch returns to IDLE.
  - fail_cnt still counts and saturates at 15.

## Structure
- Shared package ip_activate_pkg contains:
  - the state enum;
  - the CODE_W = 128 and WORD_W = 32 constants;
  - the default parameter values.
- One sub-module, act_lockout_timer, holds the lockout counter.
  - Ports: load pulse, count value, expired pulse.
  - It is instantiated only under ACT_CTRL_LOCKOUT_EN.

## Test plan
- **Correct code:** load words 87C0D0FD, 94C369FA, 1A4B7E7B, C00BD074, then check_req, with the comparator model matching → done = 1 and pass = 1 at N+3 (SETTLE_CYCLES = 2), ip_enabled = 1, fail_cnt = 0, activation_code = 0 afterwards.
- **Lockout:** 3 checks with all-zero code → fail_cnt goes 1, 2, 3; locked = 1 after the 3rd; wr_ready = 0 for exactly 1024 cycles; then IDLE with fail_cnt = 0.
- **Lockout disabled:** same stimulus with ACT_CTRL_LOCKOUT_EN undefined → locked stays 0, fail_cnt = 3, and a 4th load is accepted immediately.
- **Illegal check:** check_req after 2 words → check_err pulses; state stays IDLE; the next 2 words complete the load and a check then proceeds normally.
- **Reset mid-check:** rst_n asserted during CHECK → all outputs at reset values immediately (asynchronous); word_cnt = 0.
- **Activate then deactivate:** correct code, then deactivate → ip_enabled = 0 the next cycle; wr_ready = 1; a new load starts at bits [127:96].

Source files
------------

// File: rtl/ip_activate_pkg.sv
// Shared types and constants for the DRM activation sequencer.
// Lockout support is selected with the ACT_CTRL_LOCKOUT_EN macro in the top level.
package ip_activate_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOADED = 3'd1,
      ST_CHECK  = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_LOCKED = 3'd4
   } state_t;

   localparam int CODE_W = 128;
   localparam int WORD_W = 32;
   localparam int LOCK_W = 20;

   localparam int DEF_SETTLE_CYCLES  = 2;
   localparam int DEF_MAX_FAILS      = 3;
   localparam int DEF_LOCKOUT_CYCLES = 1024;

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/act_lockout_timer.sv
// Lockout window down-counter; o_expired flags the last cycle of the window so the
// controller leaves LOCKED after exactly i_count cycles.
module act_lockout_timer
   import ip_activate_pkg::*;
(
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [LOCK_W-1:0] i_count,
   output logic              o_expired
);

   logic [LOCK_W-1:0] r_cnt;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_count;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_expired = (r_cnt == LOCK_W'(1));

endmodule

// File: rtl/ip_activate_ctrl.sv
// Activation-code sequencer: loads a 128-bit code, drives the comparator, latches the IP enable.
// Define ACT_CTRL_LOCKOUT_EN to enforce the lockout window after repeated failures.
module ip_activate_ctrl
   import ip_activate_pkg::*;
#(
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int MAX_FAILS      = DEF_MAX_FAILS,
   parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
)(
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              check_req,
   input  logic              deactivate,
   output logic [CODE_W-1:0] activation_code,
   input  logic              cmp_enable,
   input  logic              cmp_rdy,
   output logic              ip_enabled,
   output logic              done,
   output logic              pass,
   output logic              check_err,
   output logic              locked,
   output logic [3:0]        fail_cnt
);

   localparam logic [3:0] SETTLE_C = 4'(SETTLE_CYCLES);

   state_t            r_state;
   logic [2:0]        r_word_cnt;
   logic [CODE_W-1:0] r_code;
   logic [3:0]        r_settle;
   logic              r_ip_enabled;
   logic              r_done;
   logic              r_pass;
   logic              r_check_err;
   logic              r_locked;
   logic [3:0]        r_fail_cnt;

   logic              w_wr_fire;
   logic              w_sample;
   logic [3:0]        w_fail_next;
   logic              w_lock_hit;
   logic              w_lock_expired;

   assign wr_ready        = (r_state == ST_IDLE) && (r_word_cnt < 3'd4);
   assign w_wr_fire       = wr_valid && wr_ready;
   assign activation_code = (r_state == ST_CHECK) ? r_code : '0;
   assign w_sample        = (r_state == ST_CHECK) && (r_settle == 4'd0) && cmp_rdy;
   assign w_fail_next     = sat_inc4(r_fail_cnt);

`ifdef ACT_CTRL_LOCKOUT_EN
   localparam logic [3:0] MAX_FAILS_C = 4'(MAX_FAILS);

   assign w_lock_hit = w_sample && !cmp_enable && (w_fail_next >= MAX_FAILS_C);

   act_lockout_timer u_lockout_timer (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .i_load    (w_lock_hit),
      .i_count   (LOCK_W'(LOCKOUT_CYCLES)),
      .o_expired (w_lock_expired)
   );
`else
   // Lockout parameters have no effect in this build; folded here so they stay referenced.
   logic w_unused_lock_cfg;
   assign w_unused_lock_cfg = (MAX_FAILS == 0) || (LOCKOUT_CYCLES == 0);
   assign w_lock_hit        = 1'b0;
   assign w_lock_expired    = 1'b0;
`endif

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_word_cnt   <= 3'd0;
         r_code       <= '0;
         r_settle     <= 4'd0;
         r_ip_enabled <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_check_err  <= 1'b0;
         r_locked     <= 1'b0;
         r_fail_cnt   <= 4'd0;
      end else begin
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         // Only LOADED accepts a check; anywhere else the request is flagged and dropped.
         r_check_err <= check_req && (r_state != ST_LOADED);

         case (r_state)
            ST_IDLE: begin
               if (w_wr_fire) begin
                  case (r_word_cnt[1:0])
                     2'd0:    r_code[3*WORD_W +: WORD_W] <= wr_data;
                     2'd1:    r_code[2*WORD_W +: WORD_W] <= wr_data;
                     2'd2:    r_code[1*WORD_W +: WORD_W] <= wr_data;
                     default: r_code[0 +: WORD_W]        <= wr_data;
                  endcase
                  r_word_cnt <= r_word_cnt + 3'd1;
                  if (r_word_cnt == 3'd3) begin
                     r_state <= ST_LOADED;
                  end
               end
            end

            ST_LOADED: begin
               if (check_req) begin
                  r_settle <= SETTLE_C;
                  r_state  <= ST_CHECK;
               end
            end

            ST_CHECK: begin
               if (r_settle != 4'd0) begin
                  r_settle <= r_settle - 4'd1;
               end else if (cmp_rdy) begin
                  r_done     <= 1'b1;
                  r_pass     <= cmp_enable;
                  r_code     <= '0;
                  r_word_cnt <= 3'd0;
                  if (cmp_enable) begin
                     r_ip_enabled <= 1'b1;
                     r_fail_cnt   <= 4'd0;
                     r_state      <= ST_ACTIVE;
                  end else begin
                     r_fail_cnt <= w_fail_next;
                     r_locked   <= w_lock_hit;
                     r_state    <= w_lock_hit ? ST_LOCKED : ST_IDLE;
                  end
               end
            end

            ST_ACTIVE: begin
               if (deactivate) begin
                  r_ip_enabled <= 1'b0;
                  r_state      <= ST_IDLE;
               end
            end

            ST_LOCKED: begin
               if (w_lock_expired) begin
                  r_locked   <= 1'b0;
                  r_fail_cnt <= 4'd0;
                  r_state    <= ST_IDLE;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ip_enabled = r_ip_enabled;
   assign done       = r_done;
   assign pass       = r_pass;
   assign check_err  = r_check_err;
   assign locked     = r_locked;
   assign fail_cnt   = r_fail_cnt;

endmodule

// File: tb/tb_ip_activate_ctrl.sv
// Directed bench for ip_activate_ctrl with a behavioural comparator that matches one fixed key.
// Lockout checks follow ACT_CTRL_LOCKOUT_EN, matching the build of the design.
module tb_ip_activate_ctrl;

   localparam logic [127:0] KEY = 128'h87C0D0FD_94C369FA_1A4B7E7B_C00BD074;

   logic         clk_in = 1'b0;
   logic         rst_n = 1'b0;
   logic         wr_valid = 1'b0;
   logic         wr_ready;
   logic [31:0]  wr_data = '0;
   logic         check_req = 1'b0;
   logic         deactivate = 1'b0;
   logic [127:0] activation_code;
   logic         cmp_enable;
   logic         cmp_rdy = 1'b1;
   logic         ip_enabled;
   logic         done;
   logic         pass;
   logic         check_err;
   logic         locked;
   logic [3:0]   fail_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [127:0] code;
      logic         exp_pass;
      logic [3:0]   exp_fail;
      logic         exp_rdy;
   } vec_t;

   vec_t vecs[4];

   always #5 clk_in = ~clk_in;

   assign cmp_enable = (activation_code == KEY);

   ip_activate_ctrl dut (
      .clk_in          (clk_in),
      .rst_n           (rst_n),
      .wr_valid        (wr_valid),
      .wr_ready        (wr_ready),
      .wr_data         (wr_data),
      .check_req       (check_req),
      .deactivate      (deactivate),
      .activation_code (activation_code),
      .cmp_enable      (cmp_enable),
      .cmp_rdy         (cmp_rdy),
      .ip_enabled      (ip_enabled),
      .done            (done),
      .pass            (pass),
      .check_err       (check_err),
      .locked          (locked),
      .fail_cnt        (fail_cnt)
   );

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_wr_ready"}, wr_ready, 1);
      chk({nm, "_ip_enabled"}, ip_enabled, 0);
      chk({nm, "_done"}, done, 0);
      chk({nm, "_pass"}, pass, 0);
      chk({nm, "_check_err"}, check_err, 0);
      chk({nm, "_locked"}, locked, 0);
      chk({nm, "_fail_cnt"}, fail_cnt, 0);
      chk({nm, "_code"}, activation_code, 0);
   endtask

   task automatic load_part(input logic [127:0] code, input int first, input int n);
      int waits;
      for (int i = first; i < first + n; i++) begin
         wr_valid = 1'b1;
         wr_data  = code[(127 - 32*i) -: 32];
         waits = 0;
         while (!wr_ready && waits < 20) begin
            tick();
            waits++;
         end
         chk("load_ready", wr_ready, 1);
         tick();
      end
      wr_valid = 1'b0;
   endtask

   task automatic do_check(input logic [127:0] code, input logic exp_pass,
                           input logic [3:0] exp_fail, input string nm);
      int lat;
      check_req = 1'b1;
      tick();
      check_req = 1'b0;
      chk({nm, "_code_driven"}, activation_code, code);
      chk({nm, "_no_early_done"}, done, 0);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!done && lat < 20);
      chk({nm, "_latency"}, lat, 3);
      chk({nm, "_pass"}, pass, exp_pass);
      chk({nm, "_ip_enabled"}, ip_enabled, exp_pass);
      chk({nm, "_fail_cnt"}, fail_cnt, exp_fail);
      chk({nm, "_code_cleared"}, activation_code, 0);
   endtask

   task automatic do_deactivate(input string nm);
      deactivate = 1'b1;
      tick();
      deactivate = 1'b0;
      chk({nm, "_ip_off"}, ip_enabled, 0);
      chk({nm, "_wr_ready"}, wr_ready, 1);
      chk({nm, "_done_low"}, done, 0);
   endtask

   initial begin
      int cnt;
      logic [3:0] exp_f;

      vecs[0] = '{KEY,                      1'b1, 4'd0, 1'b0};
      vecs[1] = '{128'h0,                   1'b0, 4'd1, 1'b1};
      vecs[2] = '{KEY ^ (128'h1 << 77),     1'b0, 4'd2, 1'b1};
      vecs[3] = '{KEY,                      1'b1, 4'd0, 1'b0};

      #12;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();
      check_reset_outputs("post_reset");

      deactivate = 1'b1;
      tick();
      deactivate = 1'b0;
      chk("deact_idle_ready", wr_ready, 1);
      chk("deact_idle_ip", ip_enabled, 0);

      for (int v = 0; v < 4; v++) begin
         load_part(vecs[v].code, 0, 4);
         chk($sformatf("vec%0d_loaded_ready", v), wr_ready, 0);
         do_check(vecs[v].code, vecs[v].exp_pass, vecs[v].exp_fail, $sformatf("vec%0d", v));
         chk($sformatf("vec%0d_ready_after", v), wr_ready, vecs[v].exp_rdy);
         if (vecs[v].exp_pass) begin
            do_deactivate($sformatf("vec%0d_deact", v));
         end else begin
            tick();
            chk($sformatf("vec%0d_done_pulse", v), done, 0);
         end
      end

      // check_req after only two words
      load_part(KEY, 0, 2);
      check_req = 1'b1;
      tick();
      check_req = 1'b0;
      chk("illegal_check_err", check_err, 1);
      chk("illegal_still_idle", wr_ready, 1);
      chk("illegal_no_done", done, 0);
      tick();
      chk("illegal_err_pulse", check_err, 0);
      load_part(KEY, 2, 2);
      do_check(KEY, 1'b1, 4'd0, "after_illegal");

      // check_req and deactivate together in ACTIVE
      check_req  = 1'b1;
      deactivate = 1'b1;
      tick();
      check_req  = 1'b0;
      deactivate = 1'b0;
      chk("both_check_err", check_err, 1);
      chk("both_ip_off", ip_enabled, 0);
      chk("both_wr_ready", wr_ready, 1);
      chk("both_no_done", done, 0);

      // comparator not ready: result waits for cmp_rdy
      load_part(KEY, 0, 4);
      cmp_rdy   = 1'b0;
      check_req = 1'b1;
      tick();
      check_req = 1'b0;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done) cnt++;
      end
      chk("stall_no_done", cnt, 0);
      chk("stall_code_held", activation_code, KEY);
      cmp_rdy = 1'b1;
      tick();
      chk("stall_done", done, 1);
      chk("stall_pass", pass, 1);
      chk("stall_ip", ip_enabled, 1);
      do_deactivate("stall_deact");

      // three consecutive failures
      for (int k = 1; k <= 3; k++) begin
         load_part(128'h0, 0, 4);
         do_check(128'h0, 1'b0, 4'(k), $sformatf("fail%0d", k));
         if (k < 3) begin
            tick();
         end
      end
`ifdef ACT_CTRL_LOCKOUT_EN
      chk("lock_locked", locked, 1);
      chk("lock_wr_ready", wr_ready, 0);
      cnt = 0;
      while (!wr_ready && cnt < 2000) begin
         cnt++;
         if (cnt == 10) check_req = 1'b1;
         tick();
         if (cnt == 10) begin
            check_req = 1'b0;
            chk("lock_check_err", check_err, 1);
         end
      end
      chk("lock_window_len", cnt, 1024);
      chk("lock_released", locked, 0);
      chk("lock_fail_cleared", fail_cnt, 0);
`else
      chk("nolock_locked", locked, 0);
      chk("nolock_fail3", fail_cnt, 3);
      chk("nolock_ready_now", wr_ready, 1);
      tick();
      for (int k = 4; k <= 16; k++) begin
         load_part(128'h0, 0, 4);
         exp_f = (k > 15) ? 4'd15 : 4'(k);
         do_check(128'h0, 1'b0, exp_f, $sformatf("sat%0d", k));
         chk($sformatf("sat%0d_locked", k), locked, 0);
         tick();
      end
      load_part(KEY, 0, 4);
      do_check(KEY, 1'b1, 4'd0, "nolock_recover");
      do_deactivate("nolock_deact");
`endif

      // asynchronous reset in the middle of a check
      load_part(128'h0, 0, 4);
      do_check(128'h0, 1'b0, 4'd1, "pre_reset_fail");
      tick();
      load_part(KEY, 0, 4);
      check_req = 1'b1;
      tick();
      check_req = 1'b0;
      chk("midcheck_code", activation_code, KEY);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      #1;
      rst_n = 1'b1;
      tick();
      check_reset_outputs("after_async_reset");
      load_part(KEY, 0, 4);
      do_check(KEY, 1'b1, 4'd0, "post_reset_load");
      do_deactivate("final_deact");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
